// File: rtl/multislice_add_ctrl_pkg.sv
// Shared constants for the multi-slice adder controller: slice width and FSM encoding.
package multislice_add_ctrl_pkg;

  localparam int SLICE_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder_3_bit.sv
// 3-bit adder slice with carry-in and carry-out; purely combinational.
module adder_3_bit (
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       cin,
  output logic [2:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {3'b000, cin};

endmodule

// File: rtl/multislice_add_ctrl.sv
// Computes {cout,sum} = a + b + cin by time-multiplexing one 3-bit adder slice
// over SLICES cycles, LSB slice first, with a registered done pulse.
module multislice_add_ctrl
  import multislice_add_ctrl_pkg::*;
#(
  parameter  int SLICES = 3,
  localparam int W      = SLICE_W * SLICES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [W-1:0]       a_q,     a_d;
  logic [W-1:0]       b_q,     b_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       sum_q,   sum_d;
  logic               cout_q,  cout_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;
  logic               slice_cout;

  // Operand slices are selected by idx; only one adder exists.
  assign slice_a = a_q[int'(idx_q) * SLICE_W +: SLICE_W];
  assign slice_b = b_q[int'(idx_q) * SLICE_W +: SLICE_W];

  adder_3_bit u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(idx_q) * SLICE_W +: SLICE_W] = slice_sum;
        carry_d = slice_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_cout;
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments; every register, operands included,
  // is reset so nothing from an aborted operation survives into the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_multislice_add_ctrl.sv
// Scoreboard bench for multislice_add_ctrl: an edge-level model predicts accepted
// operations and their completion cycle; a negedge monitor compares against the DUT.
module tb_multislice_add_ctrl;

  localparam int SLICES = 3;
  localparam int W      = 3 * SLICES;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         cin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  multislice_add_ctrl #(.SLICES(SLICES)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           due;
  } exp_t;

  exp_t         sb[$];
  exp_t         e_acc, e_mon;
  int           cyc      = 0;
  int           free_at  = 0;
  int           last_acc = -1000;
  int           rst_edge = -1;
  int           s_tot;
  bit           seen_rst = 1'b0;
  bit           exp_busy, exp_done;
  logic [W-1:0] hold_sum  = '0;
  logic         hold_cout = 1'b0;
  int           errors = 0;
  int           checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Model: decides at each edge whether a start is accepted and when it completes.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
      free_at   = cyc + 1;
      last_acc  = -1000;
      rst_edge  = cyc;
      seen_rst  = 1'b1;
      hold_sum  = '0;
      hold_cout = 1'b0;
    end else if (seen_rst && start && cyc >= free_at) begin
      s_tot      = int'(a) + int'(b) + int'(cin);
      e_acc.sum  = W'(s_tot);
      e_acc.cout = (s_tot >= (1 << W));
      e_acc.due  = cyc + SLICES;
      sb.push_back(e_acc);
      free_at    = cyc + SLICES + 2;
      last_acc   = cyc;
    end
  end

  // Monitor: samples mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (seen_rst) begin
      if (cyc == rst_edge) begin
        check("reset_sum_cout", int'({cout, sum}), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
      end else begin
        exp_busy = (cyc >= last_acc) && (cyc <= last_acc + SLICES);
        exp_done = (sb.size() > 0) && (sb[0].due == cyc);
        check("busy", int'(busy), int'(exp_busy));
        check("done", int'(done), int'(exp_done));
        if (exp_done) begin
          e_mon = sb.pop_front();
          check("result", int'({cout, sum}), int'({e_mon.cout, e_mon.sum}));
          hold_sum  = e_mon.sum;
          hold_cout = e_mon.cout;
        end else if (!exp_busy) begin
          check("idle_hold", int'({cout, sum}), int'({hold_cout, hold_sum}));
        end
      end
    end
  end

  task automatic drive(input bit r, input bit s, input int av, input int bv, input bit c);
    rst   = r;
    start = s;
    a     = W'(av);
    b     = W'(bv);
    cin   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    drive(1'b1, 1'b0, 0, 0, 1'b0);
    drive(1'b1, 1'b0, 0, 0, 1'b0);

    // Basic, full carry ripple, max operands.
    drive(1'b0, 1'b1, 100, 27, 1'b0);    idle(5);
    drive(1'b0, 1'b1, 'h1FF, 0, 1'b1);   idle(5);
    drive(1'b0, 1'b1, 'h1FF, 'h1FF, 1'b1); idle(5);

    // Start held through RUN and DONE with different operands: must be ignored.
    drive(1'b0, 1'b1, 10, 20, 1'b0);
    for (int i = 0; i < SLICES + 1; i++) drive(1'b0, 1'b1, 200, 300, 1'b1);
    idle(5);

    // Reset while idx = 1, then a fresh operation.
    drive(1'b0, 1'b1, 50, 60, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 1'b0);
    drive(1'b1, 1'b0, 0, 0, 1'b0);
    drive(1'b0, 1'b1, 5, 6, 1'b0);       idle(5);

    // Back-to-back with start held high.
    drive(1'b0, 1'b1, 3, 4, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 500, 20, 1'b0);
    idle(6);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 60) == 0), ($urandom_range(0, 2) != 0),
            int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
            1'($urandom_range(0, 1)));
    end
    idle(SLICES + 5);

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
